// File: rtl/dll_pkg.sv
// Shared data-link-layer definitions: DL control states, InitFC DLLP type bytes,
// flow-control field widths and the helper that assembles an InitFC DLLP body.
package dll_pkg;

   typedef enum logic [1:0] {
      DL_INACTIVE = 2'b00,
      DL_INIT1    = 2'b01,
      DL_INIT2    = 2'b10,
      DL_ACTIVE   = 2'b11
   } dl_state_t;

   localparam int HDR_FC_W  = 8;
   localparam int DATA_FC_W = 12;

   localparam logic [7:0] DLLP_INITFC1_P   = 8'h40;
   localparam logic [7:0] DLLP_INITFC1_NP  = 8'h50;
   localparam logic [7:0] DLLP_INITFC1_CPL = 8'h60;
   localparam logic [7:0] DLLP_INITFC2_P   = 8'hC0;
   localparam logic [7:0] DLLP_INITFC2_NP  = 8'hD0;
   localparam logic [7:0] DLLP_INITFC2_CPL = 8'hE0;

   typedef enum logic [1:0] {
      FC_P   = 2'd0,
      FC_NP  = 2'd1,
      FC_CPL = 2'd2
   } fc_kind_t;

   typedef struct packed {
      logic [HDR_FC_W-1:0]  ph;
      logic [HDR_FC_W-1:0]  nph;
      logic [HDR_FC_W-1:0]  cplh;
      logic [DATA_FC_W-1:0] pd;
      logic [DATA_FC_W-1:0] npd;
      logic [DATA_FC_W-1:0] cpld;
   } fc_credits_t;

   // Body layout: [31:24] type, [23:22] 00, [21:14] HdrFC, [13:12] 00, [11:0] DataFC.
   function automatic logic [31:0] initfc_dllp(input logic        phase2,
                                               input fc_kind_t    kind,
                                               input fc_credits_t cr);
      logic [7:0]           typ;
      logic [HDR_FC_W-1:0]  hdr;
      logic [DATA_FC_W-1:0] dat;
      case (kind)
         FC_NP: begin
            typ = phase2 ? DLLP_INITFC2_NP : DLLP_INITFC1_NP;
            hdr = cr.nph;
            dat = cr.npd;
         end
         FC_CPL: begin
            typ = phase2 ? DLLP_INITFC2_CPL : DLLP_INITFC1_CPL;
            hdr = cr.cplh;
            dat = cr.cpld;
         end
         default: begin
            typ = phase2 ? DLLP_INITFC2_P : DLLP_INITFC1_P;
            hdr = cr.ph;
            dat = cr.pd;
         end
      endcase
      return {typ, 2'b00, hdr, 2'b00, dat};
   endfunction

endpackage

// File: rtl/dll_initfc_timer.sv
// Resend interval counter: counts while enabled, flags done at RESEND_CYCLES-1.
module dll_initfc_timer #(
   parameter int RESEND_CYCLES = 8500
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_done
);
   localparam int               CNT_W = $clog2(RESEND_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(RESEND_CYCLES - 1);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_done = (r_count == LAST);

endmodule

// File: rtl/dll_initfc_tx.sv
// InitFC transmitter: sends the P/NP/Cpl InitFC1 or InitFC2 set during link
// initialisation and repeats it every RESEND_CYCLES idle cycles.
module dll_initfc_tx
   import dll_pkg::*;
#(
   parameter int RESEND_CYCLES = 8500
) (
   input  logic                 clk,
   input  logic                 rst,
   input  dl_state_t            dl_state_i,
   input  logic [HDR_FC_W-1:0]  ph_i,
   input  logic [HDR_FC_W-1:0]  nph_i,
   input  logic [HDR_FC_W-1:0]  cplh_i,
   input  logic [DATA_FC_W-1:0] pd_i,
   input  logic [DATA_FC_W-1:0] npd_i,
   input  logic [DATA_FC_W-1:0] cpld_i,
   output logic                 dllp_valid_o,
   input  logic                 dllp_ready_i,
   output logic [31:0]          dllp_data_o,
   output logic                 initfc1_sent_o,
   output logic                 initfc2_sent_o
);
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEND_P,
      ST_SEND_NP,
      ST_SEND_CPL,
      ST_WAIT
   } tx_state_t;

   tx_state_t   r_state,    w_state_nxt;
   logic        r_phase2,   w_phase2_nxt;
   fc_credits_t r_credits,  w_credits_nxt;
   logic        r_valid,    w_valid_nxt;
   logic [31:0] r_data,     w_data_nxt;
   logic        r_fc1_sent, w_fc1_nxt;
   logic        r_fc2_sent, w_fc2_nxt;
   fc_kind_t    w_kind;
   logic        w_accept;
   logic        w_phase_up;
   logic        w_timer_clear;
   logic        w_timer_en;
   logic        w_timer_done;

   dll_initfc_timer #(
      .RESEND_CYCLES (RESEND_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_timer_clear),
      .i_enable (w_timer_en),
      .o_done   (w_timer_done)
   );

   assign w_accept   = r_valid & dllp_ready_i;
   assign w_phase_up = ~r_phase2 & (dl_state_i == DL_INIT2);

   always_comb begin
      // NOTE: every variable driven here gets a default first, so no latch is inferred.
      w_state_nxt   = r_state;
      w_phase2_nxt  = r_phase2;
      w_credits_nxt = r_credits;
      w_fc1_nxt     = r_fc1_sent;
      w_fc2_nxt     = r_fc2_sent;

      case (r_state)
         ST_IDLE: begin
            // INIT2 seen first still latches credits; only the phase differs.
            if (dl_state_i == DL_INIT1 || dl_state_i == DL_INIT2) begin
               w_credits_nxt = '{ph: ph_i, nph: nph_i, cplh: cplh_i,
                                 pd: pd_i, npd: npd_i, cpld: cpld_i};
               w_phase2_nxt  = (dl_state_i == DL_INIT2);
               w_state_nxt   = ST_SEND_P;
            end
         end
         ST_SEND_P, ST_SEND_NP, ST_SEND_CPL: begin
            if (w_accept) begin
               if (r_state == ST_SEND_CPL) begin
                  if (r_phase2) w_fc2_nxt = 1'b1;
                  else          w_fc1_nxt = 1'b1;
               end
               if (dl_state_i == DL_ACTIVE) begin
                  w_state_nxt = ST_IDLE;
               end else if (w_phase_up) begin
                  w_phase2_nxt = 1'b1;
                  w_state_nxt  = ST_SEND_P;
               end else begin
                  case (r_state)
                     ST_SEND_P:  w_state_nxt = ST_SEND_NP;
                     ST_SEND_NP: w_state_nxt = ST_SEND_CPL;
                     default:    w_state_nxt = ST_WAIT;
                  endcase
               end
            end
         end
         ST_WAIT: begin
            if (dl_state_i == DL_ACTIVE) begin
               w_state_nxt = ST_IDLE;
            end else if (w_phase_up) begin
               w_phase2_nxt = 1'b1;
               w_state_nxt  = ST_SEND_P;
            end else if (w_timer_done) begin
               w_state_nxt = ST_SEND_P;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase

      // Link dropping back to INACTIVE aborts everything, even a stalled handshake.
      if (dl_state_i == DL_INACTIVE) begin
         w_state_nxt  = ST_IDLE;
         w_phase2_nxt = 1'b0;
         w_fc1_nxt    = 1'b0;
         w_fc2_nxt    = 1'b0;
      end
   end

   // Outputs are derived from the next state so they can be registered directly.
   always_comb begin
      w_kind      = FC_P;
      w_valid_nxt = 1'b1;
      case (w_state_nxt)
         ST_SEND_P:   w_kind = FC_P;
         ST_SEND_NP:  w_kind = FC_NP;
         ST_SEND_CPL: w_kind = FC_CPL;
         default:     w_valid_nxt = 1'b0;
      endcase
      w_data_nxt = w_valid_nxt ? initfc_dllp(w_phase2_nxt, w_kind, w_credits_nxt) : '0;
   end

   assign w_timer_en    = (r_state == ST_WAIT);
   assign w_timer_clear = (r_state != ST_WAIT) || (w_state_nxt != ST_WAIT);

   always_ff @(posedge clk) begin
      // NOTE: sequential state is updated with non-blocking assignments only.
      if (rst) begin
         r_state    <= ST_IDLE;
         r_phase2   <= 1'b0;
         r_credits  <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_fc1_sent <= 1'b0;
         r_fc2_sent <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase2   <= w_phase2_nxt;
         r_credits  <= w_credits_nxt;
         r_valid    <= w_valid_nxt;
         r_data     <= w_data_nxt;
         r_fc1_sent <= w_fc1_nxt;
         r_fc2_sent <= w_fc2_nxt;
      end
   end

   assign dllp_valid_o   = r_valid;
   assign dllp_data_o    = r_data;
   assign initfc1_sent_o = r_fc1_sent;
   assign initfc2_sent_o = r_fc2_sent;

endmodule

// File: tb/tb_dll_initfc_tx.sv
// Self-checking bench for dll_initfc_tx: a set-level model checked every cycle,
// plus directed scenarios with hand-computed DLLP words and timing.
`timescale 1ns/1ps
module tb_dll_initfc_tx;
   import dll_pkg::*;

   localparam int RESEND = 16;

   logic        clk = 1'b0;
   logic        rst;
   dl_state_t   dl_state;
   logic [7:0]  ph, nph, cplh;
   logic [11:0] pd, npd, cpld;
   logic        ready;
   logic        valid;
   logic [31:0] data;
   logic        f1, f2;

   always #5 clk = ~clk;

   dll_initfc_tx #(.RESEND_CYCLES(RESEND)) dut (
      .clk            (clk),
      .rst            (rst),
      .dl_state_i     (dl_state),
      .ph_i           (ph),
      .nph_i          (nph),
      .cplh_i         (cplh),
      .pd_i           (pd),
      .npd_i          (npd),
      .cpld_i         (cpld),
      .dllp_valid_o   (valid),
      .dllp_ready_i   (ready),
      .dllp_data_o    (data),
      .initfc1_sent_o (f1),
      .initfc2_sent_o (f2)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: position in the set (-1 idle, 0..2 = P/NP/Cpl on the wire, 3 = waiting).
   int          m_pos   = -1;
   int          m_phase = 1;
   int          m_wait  = 0;
   bit          m_f1    = 1'b0;
   bit          m_f2    = 1'b0;
   bit          m_live  = 1'b0;
   logic [7:0]  m_hdr [3];
   logic [11:0] m_dat [3];
   int          cyc = 0;
   logic [31:0] hs_data [$];
   int          hs_cyc  [$];

   function automatic logic [31:0] m_word(input int pos);
      logic [7:0] t;
      t = 8'h40 + 8'(16 * pos) + ((m_phase == 2) ? 8'h80 : 8'h00);
      return {t, 2'b00, m_hdr[pos], 2'b00, m_dat[pos]};
   endfunction

   always @(posedge clk) begin
      if (valid === 1'b1 && ready === 1'b1) begin
         hs_data.push_back(data);
         hs_cyc.push_back(cyc);
      end
      cyc++;
      m_live = 1'b1;
      if (rst || dl_state == DL_INACTIVE) begin
         m_pos = -1; m_phase = 1; m_wait = 0; m_f1 = 1'b0; m_f2 = 1'b0;
      end else if (m_pos < 0) begin
         if (dl_state != DL_ACTIVE) begin
            m_hdr   = '{ph, nph, cplh};
            m_dat   = '{pd, npd, cpld};
            m_phase = (dl_state == DL_INIT2) ? 2 : 1;
            m_pos   = 0;
         end
      end else if (m_pos < 3) begin
         if (ready) begin
            if (m_pos == 2) begin
               if (m_phase == 2) m_f2 = 1'b1;
               else              m_f1 = 1'b1;
            end
            m_wait = 0;
            if (dl_state == DL_ACTIVE) m_pos = -1;
            else if (m_phase == 1 && dl_state == DL_INIT2) begin m_phase = 2; m_pos = 0; end
            else m_pos++;
         end
      end else begin
         if (dl_state == DL_ACTIVE) m_pos = -1;
         else if (m_phase == 1 && dl_state == DL_INIT2) begin m_phase = 2; m_pos = 0; end
         else if (m_wait == RESEND - 1) m_pos = 0;
         else m_wait++;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         check("model_valid", {31'd0, valid}, 32'(m_pos >= 0 && m_pos <= 2));
         if (m_pos >= 0 && m_pos <= 2) check("model_data", data, m_word(m_pos));
         check("model_fc1_sent", {31'd0, f1}, {31'd0, m_f1});
         check("model_fc2_sent", {31'd0, f2}, {31'd0, m_f2});
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_hs(input int target, input string name);
      int k = 0;
      while (hs_data.size() < target && k < 60) begin
         @(negedge clk);
         k++;
      end
      check(name, 32'(hs_data.size() >= target), 32'd1);
   endtask

   initial begin
      int k;
      rst = 1'b1; dl_state = DL_INACTIVE; ready = 1'b1;
      ph = 8'h20; pd = 12'h080; nph = 8'h11; npd = 12'h0F0; cplh = 8'h00; cpld = 12'h000;
      tick(3);
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_data", data, 32'd0);
      check("reset_fc1", {31'd0, f1}, 32'd0);
      check("reset_fc2", {31'd0, f2}, 32'd0);
      rst = 1'b0;
      tick(2);
      check("inactive_idle", {31'd0, valid}, 32'd0);

      // InitFC1 set with ready high: no bubbles, flag one cycle after Cpl.
      dl_state = DL_INIT1;
      tick(1);
      check("fc1_p_valid", {31'd0, valid}, 32'd1);
      check("fc1_p_data", data, 32'h40080080);
      tick(1);
      check("fc1_np_data", data, 32'h500440F0);
      tick(1);
      check("fc1_cpl_data", data, 32'h60000000);
      check("fc1_flag_early", {31'd0, f1}, 32'd0);
      tick(1);
      check("fc1_flag_set", {31'd0, f1}, 32'd1);
      check("fc1_wait_valid", {31'd0, valid}, 32'd0);

      // Resend spacing.
      wait_hs(4, "resend_timeout");
      check("resend_gap", 32'(hs_cyc[3] - hs_cyc[2]), 32'd17);
      check("resend_p", hs_data[3], 32'h40080080);

      // Ready pattern 1-0-0-1: NP held stable through two stalls.
      ready = 1'b0;
      tick(1);
      check("stall1_data", data, 32'h500440F0);
      check("stall1_valid", {31'd0, valid}, 32'd1);
      tick(1);
      check("stall2_data", data, 32'h500440F0);
      ready = 1'b1;
      tick(1);
      check("after_stall_cpl", data, 32'h60000000);
      wait_hs(6, "stall_set_timeout");
      tick(2);
      check("stall_no_dup", 32'(hs_data.size()), 32'd6);
      check("stall_np_accepted", hs_data[4], 32'h500440F0);
      check("stall_cpl_accepted", hs_data[5], 32'h60000000);

      // INIT1 -> INIT2 while NP is stalled.
      wait_hs(7, "p_before_init2_timeout");
      ready = 1'b0; dl_state = DL_INIT2;
      tick(1);
      check("np_keeps_phase1", data, 32'h500440F0);
      ready = 1'b1;
      wait_hs(8, "np_phase1_timeout");
      check("fc2_p_data", data, 32'hC0080080);
      wait_hs(9, "fc2_p_timeout");
      check("fc2_np_data", data, 32'hD00440F0);
      wait_hs(10, "fc2_np_timeout");
      check("fc2_cpl_data", data, 32'hE0000000);
      check("fc2_flag_early", {31'd0, f2}, 32'd0);
      wait_hs(11, "fc2_cpl_timeout");
      check("fc2_flag_set", {31'd0, f2}, 32'd1);
      check("fc2_seq_np", hs_data[7], 32'h500440F0);
      check("fc2_seq_cpl", hs_data[10], 32'hE0000000);

      // INACTIVE mid-set while stalled, then re-entry with new credits.
      ready = 1'b0;
      k = 0;
      while (valid !== 1'b1 && k < 40) begin tick(1); k++; end
      check("resend_fc2_timeout", {31'd0, valid}, 32'd1);
      tick(1);
      dl_state = DL_INACTIVE;
      tick(1);
      check("inactive_valid", {31'd0, valid}, 32'd0);
      check("inactive_fc1", {31'd0, f1}, 32'd0);
      check("inactive_fc2", {31'd0, f2}, 32'd0);
      ph = 8'h7F; pd = 12'hABC; nph = 8'h01; npd = 12'h001; cplh = 8'hFF; cpld = 12'hFFF;
      dl_state = DL_INIT1; ready = 1'b1;
      tick(1);
      check("new_p_data", data, 32'h401FCABC);
      tick(1);
      check("new_np_data", data, 32'h50004001);
      tick(1);
      check("new_cpl_data", data, 32'h603FCFFF);
      tick(1);
      check("new_fc1_flag", {31'd0, f1}, 32'd1);

      // INIT2 from WAIT goes straight to phase-2 P; then reset during WAIT.
      dl_state = DL_INIT2;
      tick(1);
      check("wait_to_fc2_p", data, 32'hC01FCABC);
      tick(3);
      check("new_fc2_flag", {31'd0, f2}, 32'd1);
      tick(5);
      rst = 1'b1;
      tick(1);
      check("rst_valid", {31'd0, valid}, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_fc1", {31'd0, f1}, 32'd0);
      check("rst_fc2", {31'd0, f2}, 32'd0);
      rst = 1'b0;
      tick(1);
      check("init2_entry_p", data, 32'hC01FCABC);
      check("init2_entry_fc1", {31'd0, f1}, 32'd0);

      // ACTIVE lets the pending DLLP finish, then goes idle.
      ready = 1'b0; dl_state = DL_ACTIVE;
      tick(1);
      check("active_pending_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      tick(1);
      check("active_idle_valid", {31'd0, valid}, 32'd0);
      tick(3);
      check("active_stays_idle", {31'd0, valid}, 32'd0);
      check("active_last_accepted", hs_data[hs_data.size()-1], 32'hC01FCABC);

      tick(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dll_initfc_tx.md
DLL_INITFC_TX -- requirements
Module: dll_initfc_tx

Interface
REQ-001 Parameter RESEND_CYCLES, default 8500, is the number of idle cycles between repeated InitFC sets (34 us at 250 MHz); legal range 4..65535.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 dl_state_i  in  2  DL control state: 00 INACTIVE, 01 INIT1, 10 INIT2, 11 ACTIVE.
REQ-006 ph_i, nph_i, cplh_i  in  8 each  advertised header credits (P, NP, Cpl); 0 means infinite.
REQ-007 pd_i, npd_i, cpld_i  in  12 each  advertised data credits (P, NP, Cpl); 0 means infinite.
REQ-008 dllp_valid_o  out  1  DLLP body valid toward the DLLP TX arbiter.
REQ-009 dllp_ready_i  in  1  arbiter accepts; handshake = valid & ready at a rising edge.
REQ-010 dllp_data_o  out  32  DLLP body without CRC: [31:24] type, [23:22] 00, [21:14] HdrFC, [13:12] 00, [11:0] DataFC.
REQ-011 initfc1_sent_o  out  1  sticky: at least one complete InitFC1 set was accepted.
REQ-012 initfc2_sent_o  out  1  sticky: at least one complete InitFC2 set was accepted.

Function
REQ-013 Type bytes SHALL be: InitFC1-P 0x40, -NP 0x50, -Cpl 0x60; InitFC2-P 0xC0, -NP 0xD0, -Cpl 0xE0 (VC0 only).
REQ-014 FSM states SHALL be IDLE, SEND_P, SEND_NP, SEND_CPL, WAIT; a phase bit selects FC1/FC2 type bytes.
REQ-015 All outputs SHALL be registered.
REQ-016 On the first cycle dl_state_i = INIT1 is sampled in IDLE, the block SHALL latch all six credit inputs and drive SEND_P with valid high the next cycle.
REQ-017 Latched credits SHALL remain constant until dl_state_i returns to INACTIVE, so that InitFC1 and InitFC2 carry identical values.
REQ-018 While valid is high and ready low, dllp_data_o SHALL stay stable and valid SHALL NOT drop, except per REQ-024.
REQ-019 A set SHALL be sent in the order P, NP, Cpl. Each handshake advances to the next DLLP with valid kept high, so there are no bubbles when ready is high.
REQ-020 The cycle after the Cpl handshake, the matching sent flag SHALL rise. The FSM SHALL then enter WAIT with the timer cleared.
REQ-021 In WAIT the timer SHALL count every cycle. At count RESEND_CYCLES-1 the FSM SHALL return to SEND_P with the same phase.
REQ-022 When dl_state_i changes INIT1->INIT2, any pending DLLP SHALL complete its handshake in its original phase. The next DLLP SHALL then be InitFC2-P, restarting the set, and the timer SHALL be cleared. If the FSM is in WAIT, it SHALL go directly to SEND_P with phase 2.
REQ-023 initfc2_sent_o SHALL rise only after P, NP and Cpl have all been accepted in phase 2.
REQ-024 dl_state_i = INACTIVE SHALL, on the next edge, force IDLE, valid 0, both sent flags 0 and timer 0, even mid-handshake.
REQ-025 dl_state_i = ACTIVE SHALL let any pending DLLP complete, then enter IDLE. Sent flags SHALL hold their values.
REQ-026 dl_state_i INIT2 sampled in IDLE without a prior INIT1 SHALL be treated as INIT1 entry: credits are latched and phase 2 is used.
REQ-027 Credits of value 0 SHALL be transmitted unchanged as 0.

Reset
REQ-028 With rst high: FSM = IDLE, phase = 1, timer = 0, dllp_valid_o = 0, dllp_data_o = 0, initfc1_sent_o = 0, initfc2_sent_o = 0, latched credits = 0.
REQ-029 Reset SHALL take priority over every other input.

Structure
REQ-030 Shared package dll_pkg SHALL hold: the dl_state_t enum (00/01/10/11), the six DLLP type constants, HDR_FC_W = 8 and DATA_FC_W = 12.
REQ-031 Sub-module dll_initfc_timer (clear, enable, done at RESEND_CYCLES-1, width $clog2(RESEND_CYCLES)) SHALL hold the resend counter. All other logic stays in dll_initfc_tx.
REQ-032 Target size is 150-300 lines of RTL.

Verification
REQ-033 Ready=1, INIT1 entered at cycle t, ph=0x20, pd=0x080 -> data 0x40_08_0080 at t+1, NP at t+2, Cpl at t+3, initfc1_sent_o=1 at t+4.
REQ-034 Ready toggling 1-0-0-1 during a set -> data is held stable during stalls, no DLLP is lost or duplicated, order is P,NP,Cpl.
REQ-035 RESEND_CYCLES=16, INIT1 held, ready=1 -> the second InitFC1-P is presented exactly 17 cycles after the first Cpl handshake.
REQ-036 INIT1->INIT2 while NP is stalled -> NP (0x50) completes, then 0xC0, 0xD0, 0xE0 follow; initfc2_sent_o rises only after 0xE0 is accepted.
REQ-037 INACTIVE asserted mid-set with ready=0 -> valid=0 and both flags=0 next cycle. Re-entering INIT1 with new credits sends the new credits.
REQ-038 rst pulsed during WAIT with INIT2 held -> all outputs reset. After release, the sequence restarts with InitFC2-P per REQ-026.
